adder_sweep_checker: RTL
========================

# adder_sweep_checker

Hardware initiator for the `adder` interface: it drives every `{a, b, c}` operand combination into an external three-operand adder, samples the returned sum and checks it against an internal reference. It counts mismatches and captures the first failing vector. It sits beside an `adder`/`adder_synth` instance on the lab board or in an FPGA self-test top, replacing the software sweep with a start/done handshake.

## Interface
- `width_p`, default 4: operand width; the sum is `width_p+1` bits.
- `clk_i` input 1: single clock, rising edge.
- `reset_i` input 1: asynchronous, active-high reset.
- `start_i` input 1: begins a sweep; level-sampled in IDLE or DONE only.
- `a_o`, `b_o`, `c_o` output `width_p` each: registered operands to the adder under test.
- `sum_i` input `width_p+1`: sum returned by the adder under test. The adder is combinational from `a_o`/`b_o`/`c_o`.
- `busy_o` output 1: high while in RUN.
- `done_o` output 1: high while in DONE.
- `pass_o` output 1: high in DONE when `err_count_o == 0`; low otherwise.
- `err_count_o` output `3*width_p+1`: mismatch count for the current or last sweep.
- `fail_a_o`, `fail_b_o`, `fail_c_o` output `width_p` each: operands of the first mismatch.
- `fail_sum_o` output `width_p+1`: `sum_i` value observed at the first mismatch.
- `fail_valid_o` output 1: the fail capture fields are valid.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on `start_i`.
  - RUN -> DONE after the last vector is compared.
  - DONE -> RUN on `start_i`.
  - There is no path back to IDLE except reset.
- Vector index is the concatenation `{a, b, c}`, `3*width_p` bits wide.
  - `c` is least significant.
  - The sequence is 0, 1, …, 2^(3*width_p)-1, with no gaps or repeats.
- Entering RUN:
  - index cleared to 0;
  - `err_count_o`, `fail_*` and `fail_valid_o` cleared.
- Each RUN cycle:
  - reference = `a_o + b_o + c_o`, computed at `width_p+1` bits, with no truncation of the carry;
  - if `sum_i != reference`, increment `err_count_o`;
  - if `fail_valid_o` was low, also capture `a_o`/`b_o`/`c_o`/`sum_i` and set `fail_valid_o`.
- On the last index (all ones), compare, then enter DONE.
  - Operands hold at the last vector.
  - The index does not wrap.
- `err_count_o` has `3*width_p+1` bits, so it holds the worst case 2^(3*width_p) with no saturation logic.
- `start_i` during RUN is ignored; the sweep is not restarted.
- DONE holds all results until the next `start_i`.
- `start_i` held continuously causes back-to-back sweeps with one DONE cycle between them.

## Timing
- Reset value of every output is 0, including `a_o`/`b_o`/`c_o`, and the state is IDLE.
- Reset asserted mid-RUN aborts the sweep immediately (asynchronously) to IDLE with all outputs 0.
- Cycle numbering: cycle 0 is the edge that samples `start_i` in IDLE.
- From cycle 1:
  - `busy_o = 1`;
  - vector 0 is on `a_o`/`b_o`/`c_o`;
  - `sum_i` is compared in that same cycle, so the DUT path is combinational and must fit in one clock.
- Vector k is presented in cycle k+1.
- DONE is entered at cycle 2^(3*width_p)+1: `busy_o=0`, `done_o=1`.
  - For `width_p=4` that is cycle 4097.
- Result outputs are registered.
  - A mismatch in cycle k+1 is visible on `err_count_o`/`fail_*` from cycle k+2.

## Structure
- Shared package `adder_sweep_pkg`:
  - `state_e` enum (IDLE, RUN, DONE);
  - helper function `num_vectors(width)` returning 2^(3*width).
- One natural sub-module: `sweep_counter`.
  - Parameterised width, with clear, enable, and a `last_o` flag at all ones.
  - It provides the `{a, b, c}` index.
- The FSM, reference computation and capture logic live in the top module.
- The adder under test is instantiated outside the block, by the integration top or the bench.

## Test plan
- Good `adder`, `width_p=4`, pulse `start_i` once:
  - `busy_o` for exactly 4096 cycles;
  - `done_o=1` at cycle 4097;
  - `pass_o=1`, `err_count_o=0`, `fail_valid_o=0`.
- Adder with `sum[0]` stuck at 0:
  - `err_count_o=2048`, `pass_o=0`, `fail_valid_o=1`;
  - first fail at a=0000, b=0000, c=0001, `fail_sum_o=00000`.
- Adder with carry bit `sum[4]` forced 0:
  - first fail at a=0000, b=0001, c=1111, `fail_sum_o=00000`;
  - `err_count_o` equals the count of triples with a+b+c ≥ 16, taken from the bench's own loop.
- Pulse `start_i` again at cycles 100 and 2000 during RUN:
  - `done_o` is still at cycle 4097, with no counter reset.
- Assert `reset_i` asynchronously, off clock edge, at cycle 1500:
  - all outputs drop to 0 immediately, state IDLE;
  - a new `start_i` after release gives a full clean sweep.
- From DONE after a failing sweep, swap in the good adder and pulse `start_i`:
  - fail fields and count clear on RUN entry;
  - the sweep ends `pass_o=1`.

Source files
------------

// File: rtl/adder_sweep_pkg.sv
// Shared types and helpers for the adder sweep checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adder_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of {a, b, c} operand combinations for a given operand width.
  function automatic logic [63:0] num_vectors(input int width);
    return 64'd1 << (3 * width);
  endfunction

endpackage

// File: rtl/adder_sweep_checker_if.sv
// Bundle between the sweep checker and the adder under test / controlling host.
// Latency: n/a (wires only).
// Backpressure: none; start_i is level-sampled, results are held in DONE.
// Ports (master = checker): start_i, sum_i in; operands, status and fail capture out.
interface adder_sweep_checker_if #(
  parameter int width_p = 4
);

  logic                 start_i;
  logic [width_p-1:0]   a_o;
  logic [width_p-1:0]   b_o;
  logic [width_p-1:0]   c_o;
  logic [width_p:0]     sum_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 pass_o;
  logic [3*width_p:0]   err_count_o;
  logic [width_p-1:0]   fail_a_o;
  logic [width_p-1:0]   fail_b_o;
  logic [width_p-1:0]   fail_c_o;
  logic [width_p:0]     fail_sum_o;
  logic                 fail_valid_o;

  modport master (
    input  start_i, sum_i,
    output a_o, b_o, c_o, busy_o, done_o, pass_o, err_count_o,
           fail_a_o, fail_b_o, fail_c_o, fail_sum_o, fail_valid_o
  );

  modport slave (
    output start_i, sum_i,
    input  a_o, b_o, c_o, busy_o, done_o, pass_o, err_count_o,
           fail_a_o, fail_b_o, fail_c_o, fail_sum_o, fail_valid_o
  );

endinterface

// File: rtl/sweep_counter.sv
// Vector index counter: clears to 0, counts up on enable, stops at all ones.
// Latency: count_o is registered, one cycle after clear/enable.
// Backpressure: none; en_i is ignored once last_o is high (no wrap).
// Ports: clk_i, reset_i (async, active high), clear_i, en_i, count_o, last_o.
module sweep_counter #(
  parameter int width_p = 12
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               en_i,
  output logic [width_p-1:0] count_o,
  output logic               last_o
);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_o <= '0;
    end else if (clear_i) begin
      count_o <= '0;
    end else if (en_i && !last_o) begin
      count_o <= count_o + width_p'(1);
    end
  end

  assign last_o = &count_o;

endmodule

// File: rtl/adder_sweep_checker.sv
// Exhaustive {a,b,c} sweep of an external combinational adder with mismatch count
// and first-failure capture. Latency: vector k on operands in cycle k+1, DONE at
// 2^(3*width_p)+1; results registered. Backpressure: start_i ignored during RUN.
// Ports: clk_i, reset_i (async, active high), bus (master modport of the sweep bundle).
module adder_sweep_checker
  import adder_sweep_pkg::*;
#(
  parameter int width_p = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  adder_sweep_checker_if.master bus
);

  localparam int IDX_W = 3 * width_p;
  localparam int ERR_W = IDX_W + 1;

  state_e             state_q;
  state_e             state_d;

  logic [IDX_W-1:0]   idx;
  logic               last;
  logic               start_sweep;
  logic               cnt_en;
  logic               compare_en;

  logic [width_p:0]   ref_sum;
  logic               mismatch;

  logic [ERR_W-1:0]   err_q;
  logic [width_p-1:0] fail_a_q;
  logic [width_p-1:0] fail_b_q;
  logic [width_p-1:0] fail_c_q;
  logic [width_p:0]   fail_sum_q;
  logic               fail_valid_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_i) state_d = RUN;
      RUN:     if (last)        state_d = DONE;
      DONE:    if (bus.start_i) state_d = RUN;
      default:                  state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    start_sweep = 1'b0;
    cnt_en      = 1'b0;
    compare_en  = 1'b0;
    bus.busy_o  = 1'b0;
    bus.done_o  = 1'b0;
    bus.pass_o  = 1'b0;
    case (state_q)
      IDLE: begin
        start_sweep = bus.start_i;
      end
      RUN: begin
        // The last vector is still compared; only the index stops advancing.
        compare_en = 1'b1;
        cnt_en     = !last;
        bus.busy_o = 1'b1;
      end
      DONE: begin
        start_sweep = bus.start_i;
        bus.done_o  = 1'b1;
        bus.pass_o  = (err_q == '0);
      end
      default: begin
        start_sweep = 1'b0;
      end
    endcase
  end

  // ---------------- Vector index ----------------
  sweep_counter #(
    .width_p (IDX_W)
  ) u_sweep_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (start_sweep),
    .en_i    (cnt_en),
    .count_o (idx),
    .last_o  (last)
  );

  // The index register doubles as the operand register; c is least significant.
  assign bus.a_o = idx[IDX_W-1 -: width_p];
  assign bus.b_o = idx[2*width_p-1 -: width_p];
  assign bus.c_o = idx[width_p-1:0];

  // ---------------- Reference and compare ----------------
  // Operands are zero-extended so the carry out of a+b lands in the top bit.
  assign ref_sum  = {1'b0, bus.a_o} + {1'b0, bus.b_o} + {1'b0, bus.c_o};
  assign mismatch = (bus.sum_i != ref_sum);

  // ---------------- Result registers ----------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      err_q        <= '0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      fail_c_q     <= '0;
      fail_sum_q   <= '0;
      fail_valid_q <= 1'b0;
    end else if (start_sweep) begin
      err_q        <= '0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      fail_c_q     <= '0;
      fail_sum_q   <= '0;
      fail_valid_q <= 1'b0;
    end else if (compare_en && mismatch) begin
      // ERR_W bits cover the all-vectors-fail case, so no saturation needed.
      err_q <= err_q + ERR_W'(1);
      if (!fail_valid_q) begin
        fail_a_q     <= bus.a_o;
        fail_b_q     <= bus.b_o;
        fail_c_q     <= bus.c_o;
        fail_sum_q   <= bus.sum_i;
        fail_valid_q <= 1'b1;
      end
    end
  end

  assign bus.err_count_o  = err_q;
  assign bus.fail_a_o     = fail_a_q;
  assign bus.fail_b_o     = fail_b_q;
  assign bus.fail_c_o     = fail_c_q;
  assign bus.fail_sum_o   = fail_sum_q;
  assign bus.fail_valid_o = fail_valid_q;

endmodule
